// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage for the integer ALU: decodes I/R-type words, reads and
// bypasses operands, tracks in-flight destinations, and holds one op for execute.
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_imm,
  output logic [4:0]  out_funct,
  output logic [31:0] out_val1,
  output logic [31:0] out_val2,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  logic [5:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [15:0] imm;
  logic        is_itype;
  logic        is_rtype;
  logic        legal;
  logic [4:0]  dec_funct;
  logic [31:0] dec_val1;
  logic [31:0] dec_val2;

  logic        hit_rs1;
  logic        hit_rs2;
  logic        hit_rd;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_rd;
  logic        hazard;
  logic        slot_free;
  logic        accept;
  logic        issue;

  logic [31:0] pending;
  logic [31:0] pending_nxt;

  assign op       = in_instr[31:26];
  assign rd       = in_instr[25:21];
  assign rs1      = in_instr[20:16];
  assign rs2      = in_instr[15:11];
  assign imm      = in_instr[15:0];
  assign is_itype = op[5];
  assign is_rtype = (op == 6'b000000);
  assign legal    = is_itype || is_rtype;

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign hit_rs1 = wb_valid && (wb_addr == rs1);
  assign hit_rs2 = wb_valid && (wb_addr == rs2);
  assign hit_rd  = wb_valid && (wb_addr == rd);

  // Writeback data arriving this cycle wins over the stale register-file read.
  always_comb begin
    dec_funct = is_itype ? in_instr[30:26] : in_instr[4:0];
    dec_val1  = '0;
    if (rs1 != '0)
      dec_val1 = hit_rs1 ? wb_data : rf_rdata1;
    dec_val2  = '0;
    if (is_itype)
      dec_val2 = {{16{imm[15]}}, imm};
    else if (rs2 != '0)
      dec_val2 = hit_rs2 ? wb_data : rf_rdata2;
  end

  // A pending source or destination is only a hazard if writeback is not resolving it now.
  assign busy_rs1 = (rs1 != '0) && pending[rs1] && !hit_rs1;
  assign busy_rs2 = is_rtype && (rs2 != '0) && pending[rs2] && !hit_rs2;
  assign busy_rd  = (rd != '0) && pending[rd] && !hit_rd;
  assign hazard   = busy_rs1 || busy_rs2 || busy_rd;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (!legal || !hazard);
  assign accept    = in_valid && in_ready;
  assign issue     = accept && legal;

  // Clear from writeback first so a same-cycle set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid)
      pending_nxt[wb_addr] = 1'b0;
    if (issue && (rd != '0))
      pending_nxt[rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      out_valid  <= 1'b0;
      out_is_imm <= 1'b0;
      out_funct  <= '0;
      out_val1   <= '0;
      out_val2   <= '0;
      out_rd     <= '0;
      illegal    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      illegal <= accept && !legal;
      if (issue) begin
        out_valid  <= 1'b1;
        out_is_imm <= is_itype;
        out_funct  <= dec_funct;
        out_val1   <= dec_val1;
        out_val2   <= dec_val2;
        out_rd     <= rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a driver updates an abstract pipeline model and
// queues expected ops; a monitor pops and compares whenever execute takes an op.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_imm;
  logic [4:0]  out_funct;
  logic [31:0] out_val1;
  logic [31:0] out_val2;
  logic [4:0]  out_rd;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_imm(out_is_imm),
    .out_funct(out_funct), .out_val1(out_val1), .out_val2(out_val2),
    .out_rd(out_rd), .illegal(illegal)
  );

  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  typedef struct {
    logic        is_imm;
    logic [4:0]  funct;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t m_cur;
  bit   pend [32];
  bit   m_hold;
  bit   m_ill;
  int   cmp_n = 0;
  int   bad_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit blocked(input int s, input logic wv, input logic [4:0] wa);
    return (s != 0) && pend[s] && !(wv && (int'(wa) == s));
  endfunction

  function automatic logic [31:0] operand(input int s, input logic wv, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (s == 0) return 32'd0;
    if (wv && (int'(wa) == s)) return wd;
    return regs[s];
  endfunction

  // One clock: drive at posedge+1, check at posedge+2, advance model after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic wv,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy,
                      output bit acc);
    int op, rd, rs1, rs2;
    bit is_i, is_r, legal, rdy;
    exp_t e;
    in_valid = v; in_instr = ins; wb_valid = wv; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_hold);
    chk("illegal", illegal, m_ill);
    if (m_hold) begin
      chk("held_is_imm", out_is_imm, m_cur.is_imm);
      chk("held_funct", out_funct, m_cur.funct);
      chk("held_val1", out_val1, m_cur.v1);
      chk("held_val2", out_val2, m_cur.v2);
      chk("held_rd", out_rd, m_cur.rd);
    end
    op  = int'(ins[31:26]);
    rd  = int'(ins[25:21]);
    rs1 = int'(ins[20:16]);
    rs2 = int'(ins[15:11]);
    is_i  = (op >= 32);
    is_r  = (op == 0);
    legal = is_i || is_r;
    chk("rf_raddr1", rf_raddr1, rs1);
    chk("rf_raddr2", rf_raddr2, rs2);
    rdy = (!m_hold || ordy) &&
          (!legal || !(blocked(rs1, wv, wa) || (is_r && blocked(rs2, wv, wa)) || blocked(rd, wv, wa)));
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    e.is_imm = is_i;
    e.funct  = is_i ? ins[30:26] : ins[4:0];
    e.v1     = operand(rs1, wv, wa, wd);
    e.v2     = is_i ? 32'(signed'(ins[15:0])) : operand(rs2, wv, wa, wd);
    e.rd     = ins[25:21];
    if (acc && legal) q.push_back(e);
    @(posedge clk);
    #1;
    if (wv) pend[wa] = 1'b0;
    if (acc && legal && rd != 0) pend[rd] = 1'b1;
    if (acc && legal) begin
      m_hold = 1'b1;
      m_cur  = e;
    end else if (ordy) begin
      m_hold = 1'b0;
    end
    m_ill = acc && !legal;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    m_hold = 1'b0;
    m_ill  = 1'b0;
    q.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_is_imm", out_is_imm, 0);
    chk("rst_funct", out_funct, 0);
    chk("rst_val1", out_val1, 0);
    chk("rst_val2", out_val2, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 9);
    logic [4:0] rd  = 5'($urandom_range(0, 7));
    logic [4:0] rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [4:0] f   = 5'($urandom);
    if (k < 4) return {1'b1, f, rd, rs1, 16'($urandom)};
    if (k < 8) return {6'b000000, rd, rs1, rs2, 6'($urandom), f};
    return {1'b0, 5'($urandom_range(1, 31)), 26'($urandom)};
  endfunction

  // Execute takes the held op at the next edge whenever out_valid && out_ready here.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        cmp_n++;
        bad_n++;
        $display("FAIL unexpected_out: got out_valid=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_is_imm", out_is_imm, e.is_imm);
        chk("sb_funct", out_funct, e.funct);
        chk("sb_val1", out_val1, e.v1);
        chk("sb_val2", out_val2, e.v2);
        chk("sb_rd", out_rd, e.rd);
      end
    end
  end

  localparam logic [31:0] W4 = {6'b100001, 5'd4, 5'd0, 16'h0001};
  localparam logic [31:0] R4 = {6'b100001, 5'd6, 5'd4, 16'h0000};

  initial begin
    bit acc;
    logic [31:0] cur;
    logic        cur_v;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; wb_valid = 1'b0; wb_addr = '0;
    wb_data = '0; out_ready = 1'b0;
    foreach (regs[i]) regs[i] = $urandom;
    regs[0] = 32'hDEADBEEF;
    regs[1] = 32'd7;
    regs[2] = 32'd2;
    do_reset();

    // addi r3, r0, -1 then a reader of r3 stalls until r3 is written back
    step(1, {6'b100001, 5'd3, 5'd0, 16'hFFFF}, 0, 0, 0, 1, acc);
    step(1, {6'b100001, 5'd9, 5'd3, 16'h0004}, 0, 0, 0, 1, acc);
    step(1, {6'b100001, 5'd9, 5'd3, 16'h0004}, 1, 5'd3, 32'h55, 1, acc);
    // sll r5, r1, r2
    step(1, {6'b000000, 5'd5, 5'd1, 5'd2, 6'd0, 5'b00001}, 0, 0, 0, 1, acc);
    step(0, '0, 1, 5'd9, 0, 1, acc);
    step(0, '0, 1, 5'd5, 0, 1, acc);
    // RAW through r4 resolved by same-cycle bypass
    step(1, W4, 0, 0, 0, 1, acc);
    step(1, R4, 0, 0, 0, 1, acc);
    step(1, R4, 0, 0, 0, 1, acc);
    step(1, R4, 1, 5'd4, 32'h1234, 1, acc);
    step(0, '0, 1, 5'd6, 0, 1, acc);
    // backpressure for three cycles
    step(1, {6'b100010, 5'd7, 5'd1, 16'h8000}, 0, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) step(1, {6'b100100, 5'd8, 5'd2, 16'h7FFF}, 0, 0, 0, 0, acc);
    step(1, {6'b100100, 5'd8, 5'd2, 16'h7FFF}, 0, 0, 0, 1, acc);
    step(0, '0, 1, 5'd7, 0, 1, acc);
    step(0, '0, 1, 5'd8, 0, 1, acc);
    // illegal op claims rd=9 but must not mark it pending
    step(1, {6'b000010, 5'd9, 21'h12345}, 0, 0, 0, 1, acc);
    step(1, {6'b100001, 5'd10, 5'd9, 16'h0001}, 0, 0, 0, 1, acc);
    step(0, '0, 1, 5'd10, 0, 1, acc);
    // reset while a reader of r4 is stalled
    step(1, W4, 0, 0, 0, 0, acc);
    step(1, R4, 0, 0, 0, 0, acc);
    do_reset();
    step(1, R4, 0, 0, 0, 1, acc);
    step(0, '0, 1, 5'd6, 0, 1, acc);

    cur = rand_instr();
    cur_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        cur_v = 1'b0;
      end
      if (!cur_v && $urandom_range(0, 3) != 0) begin
        cur = rand_instr();
        cur_v = 1'b1;
      end
      step(cur_v, cur, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), acc);
      if (acc) cur_v = 1'b0;
    end
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 0, 1, acc);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/operand-issue stage feeding the integer ALU. Accepts instruction words from fetch through a valid/ready handshake and decodes them into the ALU control fields (is_imm, one-hot funct) plus operand values. It reads the register file, bypasses same-cycle writeback data, and tracks in-flight destinations with a pending-bit scoreboard. Decoded operations are held in a one-entry output register until the execute stage takes them.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers, r0 hardwired zero.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch offers in_instr
- in_ready  out  1  stage accepts in_instr this cycle (combinational)
- in_instr  in  32  instruction word
- rf_raddr1 / rf_raddr2  out  5  register-file read addresses (combinational from in_instr)
- rf_rdata1 / rf_rdata2  in  32  register-file read data (combinational, same cycle)
- wb_valid  in  1  writeback this cycle
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback value
- out_valid  out  1  decoded op held for execute
- out_ready  in  1  execute takes op
- out_is_imm  out  1  I-type op
- out_funct  out  5  one-hot ALU function
- out_val1 / out_val2  out  32  operands
- out_rd  out  5  destination register
- illegal  out  1  one-cycle pulse: illegal opcode consumed

## Operation
- Encoding: op = instr[31:26], rd = [25:21], rs1 = [20:16].
- op[5]=1 is I-type: is_imm=1, funct=instr[30:26], val2=sign-extend(instr[15:0]); rs1 is the only source.
- op=6'b000000 is R-type: is_imm=0, rs2=instr[15:11], funct=instr[4:0], val2=R[rs2].
- Any other op is illegal.
- Operand select per source s: s==0 gives 0; else if wb_valid && wb_addr==s, wb_data (bypass); else rf_rdata.
- Scoreboard: 32 pending bits; bit 0 is never set.
- hazard = any used source s≠0 with pending[s] && !(wb_valid && wb_addr==s), OR rd≠0 && pending[rd] && !(wb_valid && wb_addr==rd).
- slot_free = !out_valid || out_ready.
- Legal instr: in_ready = slot_free && !hazard. Illegal instr: in_ready = slot_free.
- Accept = in_valid && in_ready.
- Legal accept: load output register with decoded fields, out_valid←1, set pending[rd] if rd≠0.
- Illegal accept: illegal←1 next cycle. Output register and scoreboard are untouched; out_valid←0 if it was being drained.
- No accept && out_ready: out_valid←0.
- wb_valid clears pending[wb_addr]. If the same register is set by accept in the same cycle, set wins.
- A funct that is not one-hot is passed through unchecked.

## Timing
- Reset values: out_valid=0, out_is_imm=0, out_funct=0, out_val1=0, out_val2=0, out_rd=0, illegal=0, all pending=0. in_ready is combinational from this cleared state.
- Latency: accept in cycle N gives out_valid and fields in cycle N+1.
- Throughput: 1 op/cycle when out_ready=1 and there is no hazard.
- out_valid && !out_ready: all out_* held stable; in_ready=0.
- Back-to-back dependence (op B reads op A's rd): B stalls until the cycle wb_valid carries A's rd. B is accepted in that cycle with wb_data bypassed.
- Reset asserted mid-stall or while out_valid: everything clears next edge; the held op is dropped.
- illegal is high for exactly one cycle per illegal accept.

## Test plan
- Reset, then I-type addi (op=6'b100001, rd=3, rs1=0, imm=16'hFFFF), out_ready=1 -> next cycle out_valid=1, is_imm=1, funct=5'b00001, val1=0, val2=32'hFFFFFFFF, rd=3; pending[3]=1.
- R-type sll (rd=5, rs1=1, rs2=2, funct=5'b00001), rf_rdata1=7, rf_rdata2=2 -> out_is_imm=0, val1=7, val2=2, funct=5'b00001, rd=5.
- RAW hazard: op writing r4, then op reading r4 -> in_ready=0 until wb_valid with wb_addr=4 and wb_data=32'h1234 -> accepted that cycle, out_val1=32'h1234.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0. out_ready=1 -> next op issues next cycle.
- Illegal op=6'b000010 -> illegal pulses 1 cycle, out_valid unchanged, no pending bit set.
- Reset while stalled with pending[4]=1 -> next cycle out_valid=0, pending all 0, and an op reading r4 is accepted immediately.
